fixed_exp: RTL and testbench



---
 rtl/fixed_exp_pkg.sv | 45 ++++
 rtl/fixed_exp_scale.sv | 47 ++++
 rtl/fixed_exp.sv | 150 +++++++++++++++
 tb/tb_fixed_exp.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fixed_exp_pkg.sv
// fixed_exp_pkg: shared types, constants and ln(1+2^-i) table for fixed_exp.
// Table and LN2/XMAX are Q16.16; state codes are plain localparams.
package fixed_exp_pkg;

  typedef logic [31:0] q16_t;
  typedef logic [2:0]  state_t;

  localparam q16_t LN2    = 32'h0000_B172;
  localparam q16_t XMAX   = 32'h000B_1721;
  localparam q16_t Q_ONES = 32'hFFFF_FFFF;

  // k spans -17..16
  localparam int K_W = 6;

  localparam state_t S_IDLE   = 3'd0;
  localparam state_t S_REDUCE = 3'd1;
  localparam state_t S_ITER   = 3'd2;
  localparam state_t S_SCALE  = 3'd3;
  localparam state_t S_DONE   = 3'd4;

  function automatic logic [15:0] l_tab(input logic [4:0] i);
    logic [15:0] v;
    case (i)
      5'd1:    v = 16'h67CD;
      5'd2:    v = 16'h3920;
      5'd3:    v = 16'h1E27;
      5'd4:    v = 16'h0F85;
      5'd5:    v = 16'h07E1;
      5'd6:    v = 16'h03F8;
      5'd7:    v = 16'h01FE;
      5'd8:    v = 16'h0100;
      5'd9:    v = 16'h0080;
      5'd10:   v = 16'h0040;
      5'd11:   v = 16'h0020;
      5'd12:   v = 16'h0010;
      5'd13:   v = 16'h0008;
      5'd14:   v = 16'h0004;
      5'd15:   v = 16'h0002;
      5'd16:   v = 16'h0001;
      default: v = 16'h0000;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/fixed_exp_scale.sv
// exp_scale: scales the mantissa product by 2^k and drops the guard bits.
// EXP_ROUND_EN adds a half-LSB before the right shift; otherwise truncates.
module exp_scale
  import fixed_exp_pkg::*;
#(
  parameter int GUARD = 14,
  parameter int PW    = 33
) (
  input  logic                  [PW-1:0] p_i,
  input  logic signed          [K_W-1:0] k_i,
  output q16_t                           y_o,
  output logic                           ovf_o
);

  localparam int EW = PW + 32;
  localparam logic signed [7:0] GUARD_S = 8'(GUARD);

  logic signed [7:0] s;
  logic        [7:0] amt;
  logic     [EW-1:0] ext;
  logic     [EW-1:0] sh;

  always_comb begin
    s   = GUARD_S - 8'(k_i);
    ext = EW'(p_i);
    amt = 8'd0;
    sh  = '0;
    if (s[7]) begin
      amt = 8'(-s);
      sh  = ext << amt;
    end else begin
      amt = 8'(s);
`ifdef EXP_ROUND_EN
      if (amt != 8'd0) begin
        sh = (ext + (EW'(1) << (amt - 8'd1))) >> amt;
      end else begin
        sh = ext;
      end
`else
      sh = ext >> amt;
`endif
    end
    ovf_o = |sh[EW-1:32];
    y_o   = ovf_o ? Q_ONES : sh[31:0];
  end

endmodule

// File: rtl/fixed_exp.sv
// fixed_exp: sequential e^x, signed Q16.16 in, unsigned Q16.16 out.
// Define EXP_ROUND_EN for round-half-up in the final scale (default truncates).
module fixed_exp
  import fixed_exp_pkg::*;
#(
  parameter int ITERS = 16,
  parameter int GUARD = 14
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] x_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] y_out,
  output logic        sat,
  output logic        unf
);

  // product is unsigned 2.(16+GUARD) plus one headroom bit
  localparam int PW = 19 + GUARD;
  localparam logic [PW-1:0] P_ONE = PW'(1) << (16 + GUARD);
  localparam logic signed [31:0] LN2_S  = LN2;
  localparam logic signed [31:0] XMAX_S = XMAX;
  localparam logic signed [31:0] XMIN_S = -XMAX_S;

  state_t                 state_q, state_d;
  logic signed   [31:0]   r_q, r_d, r_n;
  logic signed [K_W-1:0]  k_q, k_d, k_n;
  logic        [PW-1:0]   p_q, p_d;
  logic           [4:0]   i_q, i_d;
  q16_t                   y_q, y_d;
  logic                   sat_q, sat_d;
  logic                   unf_q, unf_d;
  logic signed   [31:0]   l_i;
  q16_t                   sc_y;
  logic                   sc_ovf;

  exp_scale #(
    .GUARD(GUARD),
    .PW   (PW)
  ) u_scale (
    .p_i  (p_q),
    .k_i  (k_q),
    .y_o  (sc_y),
    .ovf_o(sc_ovf)
  );

  assign in_ready  = (state_q == S_IDLE) && !Reset;
  assign out_valid = (state_q == S_DONE);
  assign y_out     = y_q;
  assign sat       = sat_q;
  assign unf       = unf_q;

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    k_d     = k_q;
    p_d     = p_q;
    i_d     = i_q;
    y_d     = y_q;
    sat_d   = sat_q;
    unf_d   = unf_q;
    r_n     = r_q;
    k_n     = k_q;
    l_i     = 32'(l_tab(i_q));
    unique case (1'b1)
      state_q == S_IDLE: begin
        if (in_valid) begin
          y_d   = '0;
          sat_d = 1'b0;
          unf_d = 1'b0;
          r_d   = $signed(x_in);
          k_d   = '0;
          if ($signed(x_in) >= XMAX_S) begin
            state_d = S_DONE;
            y_d     = Q_ONES;
            sat_d   = 1'b1;
          end else if ($signed(x_in) < XMIN_S) begin
            state_d = S_DONE;
            unf_d   = 1'b1;
          end else begin
            state_d = S_REDUCE;
          end
        end
      end
      state_q == S_REDUCE: begin
        if (r_q < 0) begin
          r_n = r_q + LN2_S;
          k_n = k_q - K_W'(1);
        end else if (r_q >= LN2_S) begin
          r_n = r_q - LN2_S;
          k_n = k_q + K_W'(1);
        end
        r_d = r_n;
        k_d = k_n;
        // leave as soon as the residual lands in [0, ln2)
        if (r_n >= 0 && r_n < LN2_S) begin
          state_d = S_ITER;
          p_d     = P_ONE;
          i_d     = 5'd1;
        end
      end
      state_q == S_ITER: begin
        if (r_q >= l_i) begin
          r_d = r_q - l_i;
          p_d = p_q + (p_q >> i_q);
        end
        if (i_q == 5'(ITERS)) begin
          state_d = S_SCALE;
        end else begin
          i_d = i_q + 5'd1;
        end
      end
      state_q == S_SCALE: begin
        y_d     = sc_y;
        sat_d   = sc_ovf;
        state_d = S_DONE;
      end
      state_q == S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_IDLE;
      r_q     <= '0;
      k_q     <= '0;
      p_q     <= '0;
      i_q     <= '0;
      y_q     <= '0;
      sat_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      k_q     <= k_d;
      p_q     <= p_d;
      i_q     <= i_d;
      y_q     <= y_d;
      sat_q   <= sat_d;
      unf_q   <= unf_d;
    end
  end

endmodule

// File: tb/tb_fixed_exp.sv
// tb_fixed_exp: directed plus random checks of fixed_exp against real-valued e^x.
// Expected values come from $exp; out-of-range x follows the clamp rules.
module tb_fixed_exp;

  localparam int XMAXI = 32'h000B_1721;
  localparam int LAT_MAX = 1 + 17 + 16 + 1;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] x_in = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] y_out;
  logic        sat;
  logic        unf;

  int checks = 0;
  int errors = 0;

  fixed_exp dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .x_in     (x_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .y_out    (y_out),
    .sat      (sat),
    .unf      (unf)
  );

  always #5 Clk = ~Clk;

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, expv);
    end
  endtask

  task automatic chk_true(input string tag, input bit c, input int obs);
    checks++;
    assert (c) else begin
      errors++;
      $error("FAIL %s obs=%0d", tag, obs);
    end
  endtask

  task automatic chk_near(input string tag, input logic [31:0] obs,
                          input real expv, input real tol);
    real d;
    d = real'(longint'(obs)) - expv;
    if (d < 0.0) d = -d;
    checks++;
    assert (d <= tol) else begin
      errors++;
      $error("FAIL %s obs=%h exp=%f tol=%f", tag, obs, expv, tol);
    end
  endtask

  task automatic chk_res(input string tag, input logic [31:0] x,
                         input logic [31:0] y, input logic s,
                         input logic u, input int lat);
    int  xi;
    real e;
    xi = x;
    if (xi >= XMAXI) begin
      chk({tag, "_y"}, y, 32'hFFFF_FFFF);
      chk({tag, "_su"}, {30'b0, s, u}, 32'd2);
      chk_true({tag, "_lat"}, lat == 1, lat);
    end else if (xi < -XMAXI) begin
      chk({tag, "_y"}, y, 32'h0);
      chk({tag, "_su"}, {30'b0, s, u}, 32'd1);
      chk_true({tag, "_lat"}, lat == 1, lat);
    end else begin
      e = $exp(xi / 65536.0) * 65536.0;
      if (e > 4294967295.0) e = 4294967295.0;
      chk_near({tag, "_y"}, y, e, 3.0 + e * 1.0e-4);
      chk({tag, "_unf"}, 32'(u), 32'd0);
      if (s) chk({tag, "_saty"}, y, 32'hFFFF_FFFF);
      chk_true({tag, "_lat"}, lat <= LAT_MAX && lat > 1, lat);
    end
  endtask

  task automatic do_op(input logic [31:0] x, input int stall,
                       output logic [31:0] y, output logic s,
                       output logic u, output int lat);
    int n;
    n = 0;
    while (in_ready !== 1'b1 && n < 100) begin
      @(negedge Clk);
      n++;
    end
    chk_true("acc_bound", n < 100, n);
    x_in = x;
    in_valid = 1'b1;
    @(posedge Clk);
    #1 in_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge Clk);
      lat++;
    end while (out_valid !== 1'b1 && lat < 100);
    y = y_out;
    s = sat;
    u = unf;
    repeat (stall) @(negedge Clk);
    out_ready = 1'b1;
    @(posedge Clk);
    #1 out_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] y, y0, x;
    logic        s, u, s0, u0;
    int          lat, n, xi;
    real         e;

    // reset state
    @(negedge Clk);
    chk("rst_rdy", 32'(in_ready), 32'd0);
    chk("rst_ov", 32'(out_valid), 32'd0);
    chk("rst_y", y_out, 32'd0);
    chk("rst_su", {30'b0, sat, unf}, 32'd0);
    Reset = 1'b0;
    @(negedge Clk);
    chk("rst_rdy1", 32'(in_ready), 32'd1);

    // directed points
    do_op(32'h0000_0000, 0, y, s, u, lat);
    chk_near("x0", y, 65536.0, 1.0);
    chk("x0_su", {30'b0, s, u}, 32'd0);
    do_op(32'h0001_0000, 0, y, s, u, lat);
    chk_near("x1", y, 178145.0, 2.0);
    do_op(32'h0000_B172, 1, y, s, u, lat);
    chk_near("xln2", y, 131072.0, 2.0);
    do_op(32'hFFFF_0000, 0, y, s, u, lat);
    chk_near("xm1", y, 24109.0, 2.0);
    chk_res("xm1r", 32'hFFFF_0000, y, s, u, lat);

    // clamp paths and boundaries
    do_op(32'h000C_0000, 0, y, s, u, lat);
    chk_res("sat12", 32'h000C_0000, y, s, u, lat);
    do_op(32'hFFF4_0000, 0, y, s, u, lat);
    chk_res("unf12", 32'hFFF4_0000, y, s, u, lat);
    do_op(32'h000B_1721, 0, y, s, u, lat);
    chk_res("xmax", 32'h000B_1721, y, s, u, lat);
    do_op(32'h000B_1720, 0, y, s, u, lat);
    chk_res("xmaxm1", 32'h000B_1720, y, s, u, lat);
    do_op(32'hFFF4_E8DF, 0, y, s, u, lat);
    chk_res("nxmax", 32'hFFF4_E8DF, y, s, u, lat);
    do_op(32'hFFF4_E8DE, 0, y, s, u, lat);
    chk_res("nxmaxm1", 32'hFFF4_E8DE, y, s, u, lat);

    // integer sweep: e^(ln n) ~ n
    for (int k = 1; k <= 101; k++) begin
      xi = $rtoi($ln(real'(k)) * 65536.0 + 0.5);
      do_op(xi, 0, y, s, u, lat);
      e = real'(k) * 65536.0;
      chk_near("sweep", y, e, e * 1.0e-4);
    end

    // stall in DONE with a pending request
    do_op(32'h0001_0000, 0, y, s, u, lat);
    x_in = 32'h0001_0000;
    in_valid = 1'b1;
    @(posedge Clk);
    #1 in_valid = 1'b0;
    n = 0;
    do begin
      @(negedge Clk);
      n++;
    end while (out_valid !== 1'b1 && n < 100);
    chk_true("stall_lat", n < 100, n);
    y0 = y_out;
    s0 = sat;
    u0 = unf;
    chk_near("stall_first", y0, 178145.0, 2.0);
    x_in = 32'h0000_0000;
    in_valid = 1'b1;
    repeat (5) begin
      @(negedge Clk);
      chk("stall_ov", 32'(out_valid), 32'd1);
      chk("stall_rdy", 32'(in_ready), 32'd0);
      chk("stall_y", y_out, y0);
      chk("stall_su", {30'b0, sat, unf}, {30'b0, s0, u0});
    end
    out_ready = 1'b1;
    @(posedge Clk);
    #1 out_ready = 1'b0;
    @(negedge Clk);
    chk("hs_ov", 32'(out_valid), 32'd0);
    chk("hs_rdy", 32'(in_ready), 32'd1);
    @(posedge Clk);
    #1 in_valid = 1'b0;
    n = 0;
    do begin
      @(negedge Clk);
      n++;
    end while (out_valid !== 1'b1 && n < 100);
    chk_true("b2b_lat", n <= LAT_MAX, n);
    chk_near("b2b_y", y_out, 65536.0, 1.0);
    out_ready = 1'b1;
    @(posedge Clk);
    #1 out_ready = 1'b0;

    // reset in the middle of the iterations
    @(negedge Clk);
    x_in = 32'h0001_0000;
    in_valid = 1'b1;
    @(posedge Clk);
    #1 in_valid = 1'b0;
    repeat (5) @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    chk("mid_rst_ov", 32'(out_valid), 32'd0);
    chk("mid_rst_rdy", 32'(in_ready), 32'd0);
    Reset = 1'b0;
    @(negedge Clk);
    chk("post_rst_rdy", 32'(in_ready), 32'd1);
    chk("post_rst_ov", 32'(out_valid), 32'd0);
    do_op(32'hFFFF_0000, 0, y, s, u, lat);
    chk_res("post_rst_op", 32'hFFFF_0000, y, s, u, lat);

    // random operands, including out-of-range ones
    for (int t = 0; t < 60; t++) begin
      xi = int'($urandom_range(32'h0018_0000, 0)) - 786432;
      x = xi;
      do_op(x, int'($urandom_range(2, 0)), y, s, u, lat);
      chk_res("rand", x, y, s, u, lat);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
